// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: size encodings, byte counts and FSM states.
package mem_access_pkg;

   localparam logic [1:0] SIZE_BYTE    = 2'b00;
   localparam logic [1:0] SIZE_HALF    = 2'b01;
   localparam logic [1:0] SIZE_WORD    = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   localparam logic [2:0] BYTES_BYTE = 3'd1;
   localparam logic [2:0] BYTES_HALF = 3'd2;
   localparam logic [2:0] BYTES_WORD = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } accState_t;

   // Illegal encodings report a word width; they are rejected before the width is used.
   function automatic logic [2:0] sizeBytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: sizeBytes = BYTES_BYTE;
         SIZE_HALF: sizeBytes = BYTES_HALF;
         default:   sizeBytes = BYTES_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts/extends load lanes and merges store lanes into an old word.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        isUnsigned,
   input  logic [31:0] oldWord,
   input  logic [31:0] wdata,
   output logic [31:0] loadData,
   output logic [31:0] mergedWord
);

   logic [4:0]  byteShift;
   logic [4:0]  halfShift;
   logic [7:0]  laneByte;
   logic [15:0] laneHalf;

   always_comb begin
      byteShift  = {lane, 3'b000};
      halfShift  = {lane[1], 4'b0000};
      laneByte   = 8'(oldWord >> byteShift);
      laneHalf   = 16'(oldWord >> halfShift);
      loadData   = oldWord;
      mergedWord = wdata;
      case (size)
         SIZE_BYTE: begin
            loadData   = isUnsigned ? {24'b0, laneByte} : {{24{laneByte[7]}}, laneByte};
            mergedWord = (oldWord & ~(32'h0000_00FF << byteShift))
                       | ({24'b0, wdata[7:0]} << byteShift);
         end
         SIZE_HALF: begin
            loadData   = isUnsigned ? {16'b0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
            mergedWord = (oldWord & ~(32'h0000_FFFF << halfShift))
                       | ({16'b0, wdata[15:0]} << halfShift);
         end
         default: begin
            loadData   = oldWord;
            mergedWord = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a word-wide memory.
// Halfword accesses are enabled by defining MEM_ACCESS_HALFWORD_EN; otherwise size 01 is illegal.
//
// state | meaning
// IDLE  | ready for a request
// READ  | memory read strobe (load, or old word for a sub-word store)
// WRITE | memory write strobe with the final word
// RESP  | response held until the CPU accepts it
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int MEM_BYTES = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic [31:0] Address_o,
   output logic [31:0] WriteData_o,
   output logic        MemWrite_o,
   output logic        MemRead_o,
   input  logic [31:0] ReadData_i
);

   accState_t   state, nextState;
   logic [31:0] addrQ;
   logic [1:0]  sizeQ;
   logic        unsignedQ;
   logic        writeQ;
   logic [31:0] wordQ;
   logic [31:0] rdataQ;
   logic        errQ;

   logic        accept;
   logic        sizeIllegal;
   logic        misaligned;
   logic        outOfRange;
   logic        reqErr;
   logic [31:0] loadData;
   logic [31:0] mergedWord;

   always_comb begin
`ifdef MEM_ACCESS_HALFWORD_EN
      sizeIllegal = (req_size_i == SIZE_ILLEGAL);
`else
      sizeIllegal = (req_size_i == SIZE_ILLEGAL) || (req_size_i == SIZE_HALF);
`endif
      misaligned  = ((req_size_i == SIZE_WORD) && (req_addr_i[1:0] != 2'b00))
                 || ((req_size_i == SIZE_HALF) && req_addr_i[0]);
      outOfRange  = ({1'b0, req_addr_i} + 33'(sizeBytes(req_size_i))) > 33'(MEM_BYTES);
      reqErr      = sizeIllegal || misaligned || outOfRange;
      accept      = req_valid_i && (state == IDLE);
   end

   mem_lane_align uLaneAlign (
      .lane       (addrQ[1:0]),
      .size       (sizeQ),
      .isUnsigned (unsignedQ),
      .oldWord    (ReadData_i),
      .wdata      (wordQ),
      .loadData   (loadData),
      .mergedWord (mergedWord)
   );

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (reqErr)                       nextState = RESP;
               else if (!req_write_i)            nextState = READ;
               else if (req_size_i == SIZE_WORD) nextState = WRITE;
               else                              nextState = READ;
            end
         end
         READ:    nextState = writeQ ? WRITE : RESP;
         WRITE:   nextState = RESP;
         RESP:    nextState = resp_ready_i ? IDLE : RESP;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         addrQ     <= '0;
         sizeQ     <= '0;
         unsignedQ <= 1'b0;
         writeQ    <= 1'b0;
         wordQ     <= '0;
         rdataQ    <= '0;
         errQ      <= 1'b0;
      end else begin
         state <= nextState;
         case (state)
            IDLE: begin
               if (accept) begin
                  addrQ     <= req_addr_i;
                  sizeQ     <= req_size_i;
                  unsignedQ <= req_unsigned_i;
                  writeQ    <= req_write_i;
                  wordQ     <= req_wdata_i;
                  errQ      <= reqErr;
                  rdataQ    <= '0;
               end
            end
            // A sub-word store reuses wordQ to hold the merged word for WRITE.
            READ: begin
               if (writeQ) wordQ  <= mergedWord;
               else        rdataQ <= loadData;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready_o  = (state == IDLE);
      resp_valid_o = (state == RESP);
      resp_rdata_o = (state == RESP) ? rdataQ : 32'h0;
      resp_err_o   = (state == RESP) && errQ;
      MemRead_o    = (state == READ);
      MemWrite_o   = (state == WRITE);
      Address_o    = (MemRead_o || MemWrite_o) ? {addrQ[31:2], 2'b00} : 32'h0;
      WriteData_o  = MemWrite_o ? wordQ : 32'h0;
   end

endmodule
